// File: rtl/mac_share_sched_if.sv
// Bundle between requesters, the scheduler and the shared multiply-add datapath.
// The master side is the environment (requesters plus datapath); the slave side is the scheduler.
interface mac_share_sched_if #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 16,
  parameter int ID_W      = 2,
  parameter int CNT_W     = 16
);
  logic                         en;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*WIDTH_IN-1:0]  req_a;
  logic [NUM_REQ*WIDTH_IN-1:0]  req_b;
  logic [NUM_REQ*WIDTH_IN-1:0]  req_c;
  logic [WIDTH_IN-1:0]          mac_a;
  logic [WIDTH_IN-1:0]          mac_b;
  logic [WIDTH_IN-1:0]          mac_c;
  logic [WIDTH_OUT-1:0]         mac_result;
  logic                         rsp_valid;
  logic [ID_W-1:0]              rsp_id;
  logic [WIDTH_OUT-1:0]         rsp_data;
  logic                         busy;
  logic [CNT_W-1:0]             op_count;

  modport master (
    output en, req_valid, req_a, req_b, req_c, mac_result,
    input  req_ready, mac_a, mac_b, mac_c, rsp_valid, rsp_id, rsp_data, busy, op_count
  );

  modport slave (
    input  en, req_valid, req_a, req_b, req_c, mac_result,
    output req_ready, mac_a, mac_b, mac_c, rsp_valid, rsp_id, rsp_data, busy, op_count
  );
endinterface

// File: rtl/mac_share_sched.sv
// Round-robin scheduler sharing one registered multiply-add (DATA_OUT <= A*B + BUF, BUF <= C).
// C is issued one cycle ahead of A/B so BUF lines up; results return tagged with requester ID.
module mac_share_sched #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 16,
  parameter int ID_W      = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mac_share_sched_if.slave bus
);

  logic [WIDTH_IN-1:0]  w_a    [NUM_REQ];
  logic [WIDTH_IN-1:0]  w_b    [NUM_REQ];
  logic [WIDTH_IN-1:0]  w_c    [NUM_REQ];
  logic [ID_W-1:0]      w_cand [NUM_REQ];
  logic [NUM_REQ-1:0]   w_hit;
  logic [NUM_REQ-1:0]   w_take;
  logic [NUM_REQ-1:0]   w_grant;
  logic [ID_W-1:0]      w_gnt_idx;
  logic [ID_W-1:0]      w_ptr_next;
  logic                 w_accept;

  logic [ID_W-1:0]      r_ptr;
  logic                 r_s1_valid;
  logic [WIDTH_IN-1:0]  r_s1_a;
  logic [WIDTH_IN-1:0]  r_s1_b;
  logic [ID_W-1:0]      r_s1_id;
  logic                 r_s2_valid;
  logic [ID_W-1:0]      r_s2_id;
  logic                 r_s3_valid;
  logic [ID_W-1:0]      r_s3_id;
  logic [WIDTH_IN-1:0]  r_mac_a;
  logic [WIDTH_IN-1:0]  r_mac_b;
  logic [WIDTH_IN-1:0]  r_mac_c;
  logic                 r_rsp_valid;
  logic [ID_W-1:0]      r_rsp_id;
  logic [WIDTH_OUT-1:0] r_rsp_data;
  logic [CNT_W-1:0]     r_op_count;

  // Slot gi of the search order is requester (ptr + gi) mod NUM_REQ; the lowest hit slot wins.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    logic [ID_W:0] w_sum;

    assign w_a[gi]    = bus.req_a[gi*WIDTH_IN +: WIDTH_IN];
    assign w_b[gi]    = bus.req_b[gi*WIDTH_IN +: WIDTH_IN];
    assign w_c[gi]    = bus.req_c[gi*WIDTH_IN +: WIDTH_IN];
    assign w_sum      = {1'b0, r_ptr} + (ID_W+1)'(gi);
    assign w_cand[gi] = (w_sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(w_sum - (ID_W+1)'(NUM_REQ))
                                                       : w_sum[ID_W-1:0];
    assign w_hit[gi]  = bus.en & bus.req_valid[w_cand[gi]];

    if (gi == 0) begin : g_first
      assign w_take[gi] = w_hit[gi];
    end else begin : g_rest
      assign w_take[gi] = w_hit[gi] & ~(|w_hit[gi-1:0]);
    end
  end

  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_take[k]) begin
        w_grant[w_cand[k]] = 1'b1;
        w_gnt_idx          = w_cand[k];
      end
    end
  end

  assign w_accept   = |w_hit;
  assign w_ptr_next = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  // A grant is only ever issued to a valid requester, so any grant is a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_id     <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_id     <= '0;
      r_s3_valid  <= 1'b0;
      r_s3_id     <= '0;
      r_mac_a     <= '0;
      r_mac_b     <= '0;
      r_mac_c     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_op_count  <= '0;
    end else begin
      if (w_accept) begin
        r_ptr <= w_ptr_next;
      end

      r_s1_valid <= w_accept;
      r_s1_a     <= w_accept ? w_a[w_gnt_idx] : '0;
      r_s1_b     <= w_accept ? w_b[w_gnt_idx] : '0;
      r_s1_id    <= w_accept ? w_gnt_idx      : '0;
      r_mac_c    <= w_accept ? w_c[w_gnt_idx] : '0;

      r_s2_valid <= r_s1_valid;
      r_s2_id    <= r_s1_id;
      r_mac_a    <= r_s1_a;
      r_mac_b    <= r_s1_b;

      r_s3_valid <= r_s2_valid;
      r_s3_id    <= r_s2_id;

      // Datapath output for the S3 operation is stable now; capture it for the response.
      r_rsp_valid <= r_s3_valid;
      if (r_s3_valid) begin
        r_rsp_data <= bus.mac_result;
        r_rsp_id   <= r_s3_id;
        if (r_op_count != '1) begin
          r_op_count <= r_op_count + 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.mac_a     = r_mac_a;
  assign bus.mac_b     = r_mac_b;
  assign bus.mac_c     = r_mac_c;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.busy      = r_s1_valid | r_s2_valid | r_s3_valid;
  assign bus.op_count  = r_op_count;

endmodule

// File: tb/tb_mac_share_sched.sv
// Randomized scoreboard bench for mac_share_sched with a behavioural datapath and RR model.
module tb_mac_share_sched;
  localparam int N  = 4;
  localparam int WI = 8;
  localparam int WO = 16;
  localparam int IW = 2;
  localparam int CW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_share_sched_if #(.NUM_REQ(N), .WIDTH_IN(WI), .WIDTH_OUT(WO), .ID_W(IW), .CNT_W(CW)) bus ();

  mac_share_sched #(.NUM_REQ(N), .WIDTH_IN(WI), .WIDTH_OUT(WO), .ID_W(IW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shared multiply-add instance: BUF <= C, DATA_OUT <= A*B + BUF.
  logic [WO-1:0] dp_buf = '0;
  logic [WO-1:0] dp_out = '0;
  always @(posedge clk) begin
    dp_buf <= WO'(bus.mac_c);
    dp_out <= WO'(bus.mac_a) * WO'(bus.mac_b) + dp_buf;
  end
  assign bus.mac_result = dp_out;

  typedef struct {
    int          acc;
    int          due;
    logic [IW-1:0] id;
    logic [WO-1:0] data;
  } exp_t;

  exp_t q[$];
  int   exp_c[int];
  int   exp_a[int];
  int   exp_b[int];
  int   cyc    = 0;
  int   m_ptr  = 0;
  int   m_ops  = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d required %0d", nm, cyc, act, req);
    end
  endtask

  function automatic logic [N*WI-1:0] pk(input int idx, input int val);
    logic [N*WI-1:0] v;
    v = (N*WI)'(val & 8'hFF);
    return v << (idx * WI);
  endfunction

  // One request cycle: drive, predict the grant from the RR rule, record expected results.
  task automatic step(input logic [N-1:0] v, input logic e,
                      input logic [N*WI-1:0] pa, input logic [N*WI-1:0] pb, input logic [N*WI-1:0] pc);
    int g;
    int n;
    int a, b, c;
    logic [N-1:0] rdy;
    @(posedge clk);
    #1;
    bus.req_valid = v;
    bus.en        = e;
    bus.req_a     = pa;
    bus.req_b     = pb;
    bus.req_c     = pc;
    @(negedge clk);
    g = -1;
    if (e) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    rdy = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready", 64'(bus.req_ready), 64'(rdy));
    if (g >= 0) begin
      n = cyc + 1;
      a = int'(pa[g*WI +: WI]);
      b = int'(pb[g*WI +: WI]);
      c = int'(pc[g*WI +: WI]);
      exp_c[n]     = c;
      exp_a[n + 1] = a;
      exp_b[n + 1] = b;
      q.push_back('{acc: n, due: n + 3, id: IW'(g), data: WO'(a * b + c)});
      m_ptr = (g + 1) % N;
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step('0, 1'b1, '0, '0, '0);
  endtask

  // Monitor: compares every output each cycle against the scoreboard.
  always @(negedge clk) begin
    int ec, ea, eb;
    logic busy_e;
    if (rst_n) begin
      ec = exp_c.exists(cyc) ? exp_c[cyc] : 0;
      ea = exp_a.exists(cyc) ? exp_a[cyc] : 0;
      eb = exp_b.exists(cyc) ? exp_b[cyc] : 0;
      chk("mac_c", 64'(bus.mac_c), 64'(ec));
      chk("mac_a", 64'(bus.mac_a), 64'(ea));
      chk("mac_b", 64'(bus.mac_b), 64'(eb));
      busy_e = 1'b0;
      foreach (q[i]) if (q[i].acc <= cyc && q[i].due > cyc) busy_e = 1'b1;
      chk("busy", 64'(bus.busy), 64'(busy_e));
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("rsp_id", 64'(bus.rsp_id), 64'(q[0].id));
        chk("rsp_data", 64'(bus.rsp_data), 64'(q[0].data));
        $display("rsp cyc %0d id %0d data %0d", cyc, q[0].id, q[0].data);
        void'(q.pop_front());
        if (m_ops < 65535) m_ops++;
      end else begin
        chk("rsp_valid_idle", 64'(bus.rsp_valid), 64'd0);
      end
      chk("op_count", 64'(bus.op_count), 64'(m_ops));
    end
  end

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({tag, "_mac_a"}, 64'(bus.mac_a), 64'd0);
    chk({tag, "_mac_b"}, 64'(bus.mac_b), 64'd0);
    chk({tag, "_mac_c"}, 64'(bus.mac_c), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'd0);
    chk({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_op_count"}, 64'(bus.op_count), 64'd0);
  endtask

  initial begin
    logic [N-1:0] rv;
    bus.en        = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_c     = '0;
    repeat (2) @(posedge clk);
    #2;
    check_zero_outputs("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Single op from requester 1: 3*4+5 = 17.
    step(4'b0010, 1'b1, pk(1, 3), pk(1, 4), pk(1, 5));
    idle(4);

    // Back-to-back from requester 0: 7, 107, 65280.
    step(4'b0001, 1'b1, pk(0, 2), pk(0, 3), pk(0, 1));
    step(4'b0001, 1'b1, pk(0, 10), pk(0, 10), pk(0, 7));
    step(4'b0001, 1'b1, pk(0, 255), pk(0, 255), pk(0, 255));
    idle(4);

    // Contention: all four held valid for five cycles.
    for (int i = 0; i < 5; i++)
      step(4'b1111, 1'b1, 32'h04030201 + 32'(i), 32'h40302010, 32'h0D0C0B0A);
    idle(4);

    // Wrap/skip with only requesters 2 and 0 valid.
    for (int i = 0; i < 3; i++)
      step(4'b0101, 1'b1, 32'h00110022, 32'h00330044, 32'h00550066);
    idle(1);

    // en low blocks grants while an op drains; then resume from held pointer.
    step(4'b1000, 1'b1, pk(3, 9), pk(3, 9), pk(3, 9));
    for (int i = 0; i < 4; i++) step(4'b1111, 1'b0, 32'hFFFFFFFF, 32'h01010101, 32'h02020202);
    step(4'b1111, 1'b1, 32'h05060708, 32'h01020304, 32'h00000000);
    idle(4);

    // Reset while an op sits in S2: flush, expect zeros and no response.
    step(4'b0100, 1'b1, pk(2, 200), pk(2, 100), pk(2, 50));
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    q.delete();
    exp_c.delete();
    exp_a.delete();
    exp_b.delete();
    m_ptr = 0;
    m_ops = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    idle(4);
    step(4'b1111, 1'b1, 32'h04030201, 32'h01010101, 32'h00000000);
    idle(4);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rv = N'($urandom);
      step(rv, ($urandom_range(0, 4) != 0), $urandom, $urandom, $urandom);
    end
    idle(6);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
